// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared constants and types for the sprite ROM arbiter.
//   NUM_REQ_DEF / ADDR_W_DEF / DATA_W_DEF : default requester count, ROM address
//                                           width and ROM word width
//   ROM_LAT     : synchronous ROM read latency in clocks
//   PIPE_STAGES : grant -> rvalid latency (address reg + ROM + data reg)
//   idx_w()     : width of an encoded requester index (min 1 bit)
//   req_idx_t   : encoded requester index for the default configuration
package sprite_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 5;
  localparam int ROM_LAT     = 1;
  localparam int PIPE_STAGES = ROM_LAT + 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_w(NUM_REQ_DEF)-1:0] req_idx_t;
endpackage

// File: rtl/sprite_arb_picker.sv
// sprite_arb_picker: combinational grant selection.
//   req     : per-requester request
//   rr_ptr  : index where the circular search starts (tie to 0 for fixed priority)
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : encoded index of the granted requester
//   gnt_vld : a grant was issued this cycle
module sprite_arb_picker
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);
  // Walk the requesters circularly starting at rr_ptr; first hit wins.
  always_comb begin
    int cand;
    cand    = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_vld && req[cand]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = IDX_W'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM among NUM_REQ requesters.
//   vga_clk     : clock
//   reset_n     : asynchronous active-low reset
//   req         : per-requester read request (held until granted)
//   req_addr    : per-requester ROM address
//   gnt         : one-hot grant, combinational, accepted in the cycle it is high
//   rom_address : registered ROM address (holds when idle)
//   rom_q       : ROM data, valid one clock after rom_address
//   rvalid      : one-hot read-data-valid pulse, 3 cycles after gnt
//   rdata       : registered read data (holds when rvalid is 0)
// Build option: define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer). Latency is identical in both builds.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                          vga_clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_W-1:0]             rom_address,
  input  logic [DATA_W-1:0]             rom_q,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_W-1:0]             rdata
);
  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int LAST  = PIPE_STAGES - 1;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [IDX_W-1:0]   search_start;
  logic               accept;

  // Stage s holds the tag of the grant issued s cycles ago; stage 1 lines up
  // with rom_address, stage LAST with rom_q.
  logic [LAST:1]            vld_pipe_q, vld_pipe_d;
  logic [LAST:1][IDX_W-1:0] tag_pipe_q, tag_pipe_d;
  logic [ADDR_W-1:0]        rom_address_q, rom_address_d;
  logic [NUM_REQ-1:0]       rvalid_q, rvalid_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;

  sprite_arb_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (req),
    .rr_ptr  (search_start),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Grant is masked during reset so nothing is accepted while reset_n is low.
  assign accept = pick_vld & reset_n;
  assign gnt    = reset_n ? pick_gnt : '0;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  assign search_start = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept)
      rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

  assign search_start = rr_ptr_q;
`endif

  always_comb begin
    vld_pipe_d    = '0;
    tag_pipe_d    = '0;
    vld_pipe_d[1] = accept;
    tag_pipe_d[1] = pick_idx;
    for (int s = 2; s <= LAST; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      tag_pipe_d[s] = tag_pipe_q[s-1];
    end
    rom_address_d = accept ? req_addr[pick_idx] : rom_address_q;
    rvalid_d      = vld_pipe_q[LAST] ? (NUM_REQ'(1) << tag_pipe_q[LAST]) : '0;
    rdata_d       = vld_pipe_q[LAST] ? rom_q : rdata_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q    <= '0;
      tag_pipe_q    <= '0;
      rom_address_q <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
    end else begin
      vld_pipe_q    <= vld_pipe_d;
      tag_pipe_q    <= tag_pipe_d;
      rom_address_q <= rom_address_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign rom_address = rom_address_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
endmodule
